// File: rtl/brightness_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : brightness_ctrl_pkg
// Brief   : Shared FSM encoding, brightness limits and clamp helpers.
// Revision: 1.0
// ============================================================================
package brightness_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RAMP = 2'd2
    } state_t;

    localparam logic signed [15:0] BR_MIN = -16'sd128;
    localparam logic signed [15:0] BR_MAX = 16'sd127;

    function automatic logic [15:0] clamp_u16(input logic [15:0] v, input logic [15:0] hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic logic [15:0] clamp_s16(input logic signed [15:0] v,
                                              input logic signed [15:0] lo,
                                              input logic signed [15:0] hi);
        logic signed [15:0] r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/brightness_ctrl_ramp_step.sv
`default_nettype none
// ============================================================================
// Module  : ramp_step
// Brief   : Moves a value toward its target by at most one step.
// Revision: 1.0
// ============================================================================
module ramp_step #(
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic [15:0] cur_i,
    input  logic [15:0] tgt_i,
    input  logic [15:0] step_i,
    output logic [15:0] nxt_o,
    output logic        done_o
);

    logic signed [16:0] cur_x;
    logic signed [16:0] tgt_x;
    logic signed [16:0] step_x;
    logic signed [16:0] diff;
    logic signed [16:0] nxt_x;

    // One extra bit keeps the difference exact for both interpretations.
    always_comb begin
        cur_x  = SIGNED_MODE ? {cur_i[15], cur_i} : {1'b0, cur_i};
        tgt_x  = SIGNED_MODE ? {tgt_i[15], tgt_i} : {1'b0, tgt_i};
        step_x = {1'b0, step_i};
        diff   = tgt_x - cur_x;
        if (diff > step_x) begin
            nxt_x = cur_x + step_x;
        end else if (diff < -step_x) begin
            nxt_x = cur_x - step_x;
        end else begin
            nxt_x = tgt_x;
        end
        nxt_o  = nxt_x[15:0];
        done_o = (nxt_o == tgt_i);
    end

endmodule
`default_nettype wire

// File: rtl/brightness_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : brightness_ctrl
// Brief   : Frame-synchronous contrast/brightness update with jump or fade.
// Revision: 1.0
// ============================================================================
module brightness_ctrl
    import brightness_ctrl_pkg::*;
#(
    parameter int COE_MULT     = 64,
    parameter int CONTRAST_MAX = 4 * COE_MULT - 1,
    parameter int STEP_C       = 4,
    parameter int STEP_B       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_contrast_i,
    input  logic [15:0] cfg_brightness_i,
    input  logic        cfg_ramp_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        vs_i,
    output logic [15:0] contrast_o,
    output logic [15:0] brightness_o,
    output logic        upd_o,
    output logic        busy_o
);

    state_t      state_q, state_d;
    logic [15:0] tgt_c_q, tgt_c_d;
    logic [15:0] tgt_b_q, tgt_b_d;
    logic        ramp_q, ramp_d;
    logic        vs_q;
    logic [15:0] contrast_q, contrast_d;
    logic [15:0] brightness_q, brightness_d;
    logic        upd_q, upd_d;

    logic        vs_edge;
    logic [15:0] c_nxt, b_nxt;
    logic        c_done, b_done;

    assign vs_edge = vs_i & ~vs_q;

    ramp_step #(.SIGNED_MODE(1'b0)) u_step_c (
        .cur_i  (contrast_q),
        .tgt_i  (tgt_c_q),
        .step_i (16'(STEP_C)),
        .nxt_o  (c_nxt),
        .done_o (c_done)
    );

    ramp_step #(.SIGNED_MODE(1'b1)) u_step_b (
        .cur_i  (brightness_q),
        .tgt_i  (tgt_b_q),
        .step_i (16'(STEP_B)),
        .nxt_o  (b_nxt),
        .done_o (b_done)
    );

    always_comb begin
        state_d      = state_q;
        tgt_c_d      = tgt_c_q;
        tgt_b_d      = tgt_b_q;
        ramp_d       = ramp_q;
        contrast_d   = contrast_q;
        brightness_d = brightness_q;
        upd_d        = 1'b0;
        case (state_q)
            IDLE: begin
                // A frame edge seen while accepting is deliberately ignored.
                if (cfg_valid_i) begin
                    tgt_c_d = clamp_u16(cfg_contrast_i, 16'(CONTRAST_MAX));
                    tgt_b_d = clamp_s16(cfg_brightness_i, BR_MIN, BR_MAX);
                    ramp_d  = cfg_ramp_i;
                    state_d = PEND;
                end
            end
            PEND, RAMP: begin
                if (vs_edge) begin
                    if (state_q == PEND && !ramp_q) begin
                        contrast_d   = tgt_c_q;
                        brightness_d = tgt_b_q;
                        upd_d        = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        contrast_d   = c_nxt;
                        brightness_d = b_nxt;
                        upd_d        = (c_nxt != contrast_q) || (b_nxt != brightness_q);
                        state_d      = (c_done && b_done) ? IDLE : RAMP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tgt_c_q      <= 16'(COE_MULT);
            tgt_b_q      <= 16'd0;
            ramp_q       <= 1'b0;
            vs_q         <= 1'b1;
            contrast_q   <= 16'(COE_MULT);
            brightness_q <= 16'd0;
            upd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_c_q      <= tgt_c_d;
            tgt_b_q      <= tgt_b_d;
            ramp_q       <= ramp_d;
            vs_q         <= vs_i;
            contrast_q   <= contrast_d;
            brightness_q <= brightness_d;
            upd_q        <= upd_d;
        end
    end

    assign cfg_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign contrast_o   = contrast_q;
    assign brightness_o = brightness_q;
    assign upd_o        = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_brightness_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_brightness_ctrl
// Brief   : Directed and random checks of brightness_ctrl against a frame model.
// Revision: 1.0
// ============================================================================
module tb_brightness_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_contrast_i = '0;
    logic [15:0] cfg_brightness_i = '0;
    logic        cfg_ramp_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        vs_i = 1'b1;
    logic [15:0] contrast_o;
    logic [15:0] brightness_o;
    logic        upd_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    // Reference model state: applied values, pending target, mode, busy.
    int m_c, m_b, m_tc, m_tb;
    bit m_ramp, m_active;

    brightness_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_contrast_i   (cfg_contrast_i),
        .cfg_brightness_i (cfg_brightness_i),
        .cfg_ramp_i       (cfg_ramp_i),
        .cfg_valid_i      (cfg_valid_i),
        .cfg_ready_o      (cfg_ready_o),
        .vs_i             (vs_i),
        .contrast_o       (contrast_o),
        .brightness_o     (brightness_o),
        .upd_o            (upd_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mstep(input int cur, input int tgt, input int st);
        int d;
        d = tgt - cur;
        if (d > st) d = st;
        if (d < -st) d = -st;
        return cur + d;
    endfunction

    task automatic model_reset();
        m_c = 64; m_b = 0; m_active = 0; m_ramp = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_c"}, contrast_o, 16'(m_c));
        chk({tag, "_b"}, brightness_o, 16'(m_b));
        chk({tag, "_busy"}, {15'd0, busy_o}, {15'd0, m_active});
        chk({tag, "_rdy"}, {15'd0, cfg_ready_o}, {15'd0, !m_active});
    endtask

    task automatic model_accept(input logic [15:0] c, input logic [15:0] b, input bit r);
        int sb;
        m_tc = (int'(c) > 255) ? 255 : int'(c);
        sb = int'($signed(b));
        m_tb = (sb > 127) ? 127 : ((sb < -128) ? -128 : sb);
        m_ramp = r;
        m_active = 1;
    endtask

    // Present a request and hold it until the handshake completes.
    task automatic send(input logic [15:0] c, input logic [15:0] b, input bit r);
        bit done;
        done = 0;
        cfg_contrast_i = c; cfg_brightness_i = b; cfg_ramp_i = r; cfg_valid_i = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            done = cfg_ready_o;
            tick();
        end
        cfg_valid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $error("FAIL send_timeout: observed=not_accepted expected=accepted");
        end else begin
            model_accept(c, b, r);
        end
    endtask

    // One frame: raise vs, check the update, hold vs high, then drop it.
    task automatic frame(input string tag);
        int nc, nb;
        bit upd;
        upd = 0;
        vs_i = 1'b1;
        tick();
        if (m_active) begin
            if (!m_ramp) begin
                nc = m_tc; nb = m_tb; upd = 1;
                m_active = 0;
            end else begin
                nc = mstep(m_c, m_tc, 4);
                nb = mstep(m_b, m_tb, 2);
                upd = (nc != m_c) || (nb != m_b);
                m_active = !((nc == m_tc) && (nb == m_tb));
            end
            m_c = nc; m_b = nb;
        end
        chk({tag, "_upd"}, {15'd0, upd_o}, {15'd0, upd});
        check_outputs(tag);
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
        chk({tag, "_hold_upd"}, {15'd0, upd_o}, 16'd0);
        vs_i = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick();
        chk({tag, "_stable_c"}, contrast_o, 16'(m_c));
    endtask

    task automatic run_to_idle(input string tag);
        for (int i = 0; i < 200 && m_active; i++) frame(tag);
    endtask

    initial begin
        logic [15:0] rc, rb;
        bit rr;

        model_reset();
        // Reset with vs held high
        vs_i = 1'b1;
        repeat (3) tick();
        check_outputs("rst_async");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_upd", {15'd0, upd_o}, 16'd0);
        end
        check_outputs("rst");
        vs_i = 1'b0;
        tick();

        // Jump
        send(16'd128, 16'hFFEC, 1'b0);
        check_outputs("jump_pend");
        frame("jump");
        chk("jump_b_raw", brightness_o, 16'hFFEC);

        // Back to 64/0, then a fade to 74/-5
        send(16'd64, 16'd0, 1'b0);
        frame("restore");
        send(16'd74, 16'hFFFB, 1'b1);
        frame("ramp1"); chk("ramp1_c_lit", contrast_o, 16'd68);
        frame("ramp2"); chk("ramp2_b_lit", brightness_o, 16'hFFFC);
        frame("ramp3"); chk("ramp3_c_lit", contrast_o, 16'd74);
        frame("ramp_after");

        // Clamps
        send(16'h0400, 16'd300, 1'b0);
        frame("clamp_hi");
        chk("clamp_hi_lit", contrast_o, 16'd255);
        send(16'd10, 16'hFF00, 1'b0);
        frame("clamp_lo");
        chk("clamp_lo_lit", brightness_o, 16'hFF80);

        // Request accepted in the same cycle as a frame edge
        cfg_contrast_i = 16'd100; cfg_brightness_i = 16'd5; cfg_ramp_i = 1'b0;
        cfg_valid_i = 1'b1; vs_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
        model_accept(16'd100, 16'd5, 1'b0);
        chk("simul_upd", {15'd0, upd_o}, 16'd0);
        check_outputs("simul");
        tick();
        vs_i = 1'b0;
        tick();
        frame("simul_next");

        // Backpressure during a fade
        send(16'd60, 16'hFFF0, 1'b1);
        frame("bp_ramp");
        cfg_contrast_i = 16'd200; cfg_brightness_i = 16'd50; cfg_ramp_i = 1'b0;
        cfg_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready_low", {15'd0, cfg_ready_o}, 16'd0);
        end
        for (int i = 0; i < 200 && m_active; i++) begin
            vs_i = 1'b1;
            tick();
            m_c = mstep(m_c, m_tc, 4);
            m_b = mstep(m_b, m_tb, 2);
            m_active = !((m_c == m_tc) && (m_b == m_tb));
            chk("bp_c", contrast_o, 16'(m_c));
            vs_i = 1'b0;
            if (m_active) begin
                tick();
                chk("bp_hold_ready", {15'd0, cfg_ready_o}, 16'd0);
            end
        end
        chk("bp_ready_up", {15'd0, cfg_ready_o}, 16'd1);
        tick();
        cfg_valid_i = 1'b0;
        model_accept(16'd200, 16'd50, 1'b0);
        check_outputs("bp_accepted");
        frame("bp_applied");

        // Asynchronous reset in the middle of a fade
        send(16'd0, 16'hFF90, 1'b1);
        frame("rr1");
        frame("rr2");
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        frame("rst_idle_frame");

        // Random requests
        for (int t = 0; t < 8; t++) begin
            rc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 160) - 80);
            rr = 1'($urandom);
            send(rc, rb, rr);
            run_to_idle("rand");
            chk("rand_idle", {15'd0, busy_o}, 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $fatal(1, "FAIL global_timeout: observed=running expected=finished");
    end

endmodule
`default_nettype wire
